// File: rtl/pie_decoder.sv
// PIE reader-link decoder: synchronises the demodulated envelope, finds the delimiter,
// measures Tari/RTcal/TRcal and slices each rising-edge-to-rising-edge interval into a bit.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | carrier, waiting for the delimiter falling edge
// ST_DELIM | envelope low, timing the delimiter
// ST_TARI  | timing the data-0 reference symbol (value discarded)
// ST_RTCAL | timing RTcal
// ST_CAL   | next symbol is either TRcal (> rtcal) or the first data bit
// ST_DATA  | slicing data symbols until the envelope stays high past rtcal
module pie_decoder #(
    parameter int CNT_W     = 10,
    parameter int DELIM_MIN = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             demodin,
    output logic             bitout,
    output logic             bitclk,
    output logic [CNT_W-1:0] rtcal,
    output logic [CNT_W-1:0] trcal,
    output logic             trcal_valid,
    output logic             rx_active,
    output logic             rx_done,
    output logic             rx_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELIM,
        ST_TARI,
        ST_RTCAL,
        ST_CAL,
        ST_DATA
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] DELIM_MIN_C = CNT_W'(DELIM_MIN);

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt;
    logic             emitted;
    logic             bit_pend;

    logic             cnt_restart;
    logic             timeout;
    logic             rtcal_ld;
    logic             trcal_ld;
    logic             bit_ld;
    logic             bit_val;
    logic             clr_frame;
    logic             done_p;
    logic             err_p;

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign bit_val   = cnt > (rtcal >> 1);
    assign rx_active = (state == ST_TARI) || (state == ST_RTCAL) ||
                       (state == ST_CAL)  || (state == ST_DATA);

    always_comb begin
        state_nxt   = state;
        cnt_restart = rise;
        timeout     = 1'b0;
        rtcal_ld    = 1'b0;
        trcal_ld    = 1'b0;
        bit_ld      = 1'b0;
        clr_frame   = 1'b0;
        done_p      = 1'b0;
        err_p       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_nxt   = ST_DELIM;
                    cnt_restart = 1'b1;
                end
            end
            ST_DELIM: begin
                if (rise) begin
                    if (cnt >= DELIM_MIN_C) begin
                        state_nxt = ST_TARI;
                        clr_frame = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_TARI: begin
                if (rise) begin
                    state_nxt = ST_RTCAL;
                end else if (cnt == CNT_MAX) begin
                    timeout = 1'b1;
                    err_p   = 1'b1;
                end
            end
            ST_RTCAL: begin
                if (rise) begin
                    rtcal_ld  = 1'b1;
                    state_nxt = ST_CAL;
                end else if (cnt == CNT_MAX) begin
                    timeout = 1'b1;
                    err_p   = 1'b1;
                end
            end
            ST_CAL: begin
                if (rise) begin
                    trcal_ld  = cnt > rtcal;
                    bit_ld    = ~(cnt > rtcal);
                    state_nxt = ST_DATA;
                end else if ({2'b00, cnt} > {rtcal, 2'b00}) begin
                    // widened so 4x rtcal cannot wrap below a saturated counter
                    timeout = 1'b1;
                    err_p   = 1'b1;
                end
            end
            ST_DATA: begin
                if (rise) begin
                    bit_ld = 1'b1;
                end else if (cnt > rtcal) begin
                    timeout = 1'b1;
                    done_p  = emitted;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // envelope already low at timeout: that low is the next delimiter
        if (timeout) begin
            state_nxt   = s2 ? ST_IDLE : ST_DELIM;
            cnt_restart = ~s2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            s3  <= 1'b1;
            cnt <= '0;
        end else begin
            s1 <= demodin;
            s2 <= s1;
            s3 <= s2;
            if (cnt_restart) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitout      <= 1'b0;
            bit_pend    <= 1'b0;
            bitclk      <= 1'b0;
            rtcal       <= '0;
            trcal       <= '0;
            trcal_valid <= 1'b0;
            emitted     <= 1'b0;
            rx_done     <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            if (rtcal_ld) begin
                rtcal <= cnt;
            end
            if (clr_frame) begin
                trcal       <= '0;
                trcal_valid <= 1'b0;
                emitted     <= 1'b0;
            end
            if (trcal_ld) begin
                trcal       <= cnt;
                trcal_valid <= 1'b1;
            end
            if (bit_ld) begin
                bitout  <= bit_val;
                emitted <= 1'b1;
            end
            // strobe trails bitout by one cycle so the parser sees a settled bit
            bit_pend <= bit_ld;
            bitclk   <= bit_pend;
            rx_done  <= done_p;
            rx_err   <= err_p;
        end
    end

endmodule
